// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I/M opcode, funct and ALU operation constants shared by the decode stage.
package riscv_pkg;
  localparam int ALU_OP_W = 5;
  localparam logic [31:0] INST_NOP = 32'h00000013;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 5'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 5'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL    = 5'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = 5'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 5'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = 5'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL    = 5'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA    = 5'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 5'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 5'd9;
  localparam logic [ALU_OP_W-1:0] ALU_BEQ    = 5'd10;
  localparam logic [ALU_OP_W-1:0] ALU_BNE    = 5'd11;
  localparam logic [ALU_OP_W-1:0] ALU_BLT    = 5'd12;
  localparam logic [ALU_OP_W-1:0] ALU_BGE    = 5'd13;
  localparam logic [ALU_OP_W-1:0] ALU_BLTU   = 5'd14;
  localparam logic [ALU_OP_W-1:0] ALU_BGEU   = 5'd15;
  // MUL..REMU follow funct3 order so decode can offset from ALU_MUL
  localparam logic [ALU_OP_W-1:0] ALU_MUL    = 5'd16;
  localparam logic [ALU_OP_W-1:0] ALU_MULH   = 5'd17;
  localparam logic [ALU_OP_W-1:0] ALU_MULHSU = 5'd18;
  localparam logic [ALU_OP_W-1:0] ALU_MULHU  = 5'd19;
  localparam logic [ALU_OP_W-1:0] ALU_DIV    = 5'd20;
  localparam logic [ALU_OP_W-1:0] ALU_DIVU   = 5'd21;
  localparam logic [ALU_OP_W-1:0] ALU_REM    = 5'd22;
  localparam logic [ALU_OP_W-1:0] ALU_REMU   = 5'd23;
  localparam logic [ALU_OP_W-1:0] ALU_LUI    = 5'd24;
  localparam logic [ALU_OP_W-1:0] ALU_LINK   = 5'd25;

  function automatic logic [ALU_OP_W-1:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [ALU_OP_W-1:0] alu_branch(input logic [2:0] f3);
    return f3[2] ? (f3[1] ? (f3[0] ? ALU_BGEU : ALU_BLTU) : (f3[0] ? ALU_BGE : ALU_BLT))
                 : (f3[0] ? ALU_BNE : ALU_BEQ);
  endfunction
endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: IF->ID instruction handshake and ID->EX decoded-bundle handshake.
interface id_stage_if import riscv_pkg::*; #(parameter int XLEN = 32);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_inst;
  logic [XLEN-1:0]     in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [31:0]         out_inst;
  logic [ALU_OP_W-1:0] out_alu_op;
  logic [XLEN-1:0]     out_op1;
  logic [XLEN-1:0]     out_op2;
  logic [XLEN-1:0]     out_imm;
  logic [4:0]          out_rd;
  logic                out_rd_we;
  logic                out_mem_rd;
  logic                out_mem_wr;
  logic                out_illegal;
  modport master (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_alu_op, out_op1, out_op2, out_imm,
           out_rd, out_rd_we, out_mem_rd, out_mem_wr, out_illegal
  );
  modport slave (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_alu_op, out_op1, out_op2, out_imm,
           out_rd, out_rd_we, out_mem_rd, out_mem_wr, out_illegal
  );
endinterface

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate selected by the instruction format implied by the opcode.
module imm_gen import riscv_pkg::*; #(parameter int XLEN = 32) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm
);
  logic [6:0] opc;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, imm32;
  assign opc   = inst[6:0];
  assign i_imm = {{20{inst[31]}}, inst[31:20]};
  assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign u_imm = {inst[31:12], 12'b0};
  assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  always_comb
    imm32 = (opc == OP_LUI || opc == OP_AUIPC) ? u_imm :
            opc == OP_JAL    ? j_imm :
            opc == OP_BRANCH ? b_imm :
            opc == OP_STORE  ? s_imm :
            (opc == OP_IMM || opc == OP_LOAD || opc == OP_JALR) ? i_imm : '0;
  assign imm = XLEN'(imm32);
endmodule

// File: rtl/id_stage.sv
// id_stage: pipelined RV32I/M decode with load-use interlock, flush and a valid/ready output register.
module id_stage import riscv_pkg::*; #(
  parameter int          XLEN     = 32,
  parameter bit          EN_M     = 1'b0,
  parameter logic [31:0] NOP_INST = INST_NOP
) (
  input  logic            clk,
  input  logic            rst,
  id_stage_if.master      bus,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic            flush
);
  typedef struct packed {
    logic                v;
    logic [XLEN-1:0]     pc;
    logic [31:0]         inst;
    logic [ALU_OP_W-1:0] op;
    logic [XLEN-1:0]     op1;
    logic [XLEN-1:0]     op2;
    logic [XLEN-1:0]     imm;
    logic [4:0]          rd;
    logic                we;
    logic                mrd;
    logic                mwr;
    logic                ill;
  } bundle_t;
  logic [31:0] inst;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm;
  logic [ALU_OP_W-1:0] d_op;
  logic ill, wr, mrd, mwr, pc_op1, rs_op2, use1, use2, hazard, acc;
  bundle_t q, d, empty;

  assign inst     = bus.in_inst;
  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign f7       = inst[31:25];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];

  imm_gen #(.XLEN(XLEN)) u_imm (.inst(inst), .imm(imm));

  always_comb begin
    d_op = ALU_ADD;
    ill = 1'b0;
    wr = 1'b0;
    mrd = 1'b0;
    mwr = 1'b0;
    pc_op1 = 1'b0;
    rs_op2 = 1'b0;
    use1 = 1'b1;
    use2 = 1'b0;
    case (opc)
      OP_LUI:   begin d_op = ALU_LUI; wr = 1'b1; use1 = 1'b0; end
      OP_AUIPC: begin wr = 1'b1; pc_op1 = 1'b1; use1 = 1'b0; end
      OP_JAL:   begin d_op = ALU_LINK; wr = 1'b1; pc_op1 = 1'b1; use1 = 1'b0; end
      OP_JALR:  begin d_op = ALU_LINK; wr = 1'b1; pc_op1 = 1'b1; ill = f3 != 3'd0; end
      OP_BRANCH: begin
        d_op = alu_branch(f3);
        rs_op2 = 1'b1;
        use2 = 1'b1;
        ill = f3[2:1] == 2'b01;
      end
      OP_LOAD:  begin mrd = 1'b1; wr = 1'b1; ill = f3 == 3'd3 || f3 >= 3'd6; end
      OP_STORE: begin mwr = 1'b1; use2 = 1'b1; ill = f3 > 3'd2; end
      OP_IMM: begin
        d_op = alu_base(f3, f3 == 3'd5 && f7[5]);
        wr = 1'b1;
        ill = (f3 == 3'd1 && f7 != F7_BASE) || (f3 == 3'd5 && f7 != F7_BASE && f7 != F7_ALT);
      end
      OP_REG: begin
        wr = 1'b1;
        rs_op2 = 1'b1;
        use2 = 1'b1;
        d_op = f7 == F7_MULDIV ? ALU_MUL + ALU_OP_W'(f3) : alu_base(f3, f7[5]);
        ill = f7 == F7_MULDIV ? !EN_M
                              : !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OP_MISC: ;
      default: ill = 1'b1;
    endcase
  end

  // rs1/rs2 fields are compared even when the format does not carry them; use1/use2 mask those
  assign hazard = ld_valid && ld_rd != 5'd0 &&
                  ((use1 && rs1_addr == ld_rd) || (use2 && rs2_addr == ld_rd));
  assign bus.in_ready = !rst && !flush && !hazard && (!q.v || bus.out_ready);
  assign acc = bus.in_valid && bus.in_ready;

  always_comb begin
    empty = '0;
    empty.inst = NOP_INST;
    d.v = 1'b1;
    d.pc = bus.in_pc;
    d.inst = inst;
    d.op = ill ? ALU_ADD : d_op;
    d.op1 = pc_op1 ? bus.in_pc : rs1_data;
    d.op2 = rs_op2 ? rs2_data : imm;
    d.imm = imm;
    d.rd = inst[11:7];
    d.we = wr && !ill && inst[11:7] != 5'd0;
    d.mrd = mrd && !ill;
    d.mwr = mwr && !ill;
    d.ill = ill;
  end

  always_ff @(posedge clk)
    if (rst || flush) q <= empty;
    else if (acc) q <= d;
    else if (bus.out_ready) q <= empty;

  assign bus.out_valid   = q.v;
  assign bus.out_pc      = q.pc;
  assign bus.out_inst    = q.inst;
  assign bus.out_alu_op  = q.op;
  assign bus.out_op1     = q.op1;
  assign bus.out_op2     = q.op2;
  assign bus.out_imm     = q.imm;
  assign bus.out_rd      = q.rd;
  assign bus.out_rd_we   = q.we;
  assign bus.out_mem_rd  = q.mrd;
  assign bus.out_mem_wr  = q.mwr;
  assign bus.out_illegal = q.ill;

  a_xlen: assert property (@(posedge clk) XLEN == 32);
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and random stimulus on EN_M=0/1 instances against a mnemonic-level decode model.
module tb_id_stage;
  import riscv_pkg::*;
  typedef struct packed {
    logic v;
    logic [31:0] pc, inst;
    logic [4:0] op;
    logic [31:0] op1, op2, imm;
    logic [4:0] rd;
    logic we, mrd, mwr, ill;
  } bund_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1, ld_valid = 1'b0, flush = 1'b0;
  logic [31:0] in_inst = 32'h0, in_pc = 32'h0;
  logic [4:0] ld_rd = 5'd0;
  logic [4:0] rs1_a0, rs2_a0, rs1_a1, rs2_a1;
  logic [31:0] rs1_d0, rs2_d0, rs1_d1, rs2_d1;
  logic [31:0] rf [32];
  bund_t e0, e1, got0, got1, snap;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  id_stage_if #(.XLEN(32)) b0 ();
  id_stage_if #(.XLEN(32)) b1 ();
  assign b0.in_valid = in_valid;
  assign b0.in_inst = in_inst;
  assign b0.in_pc = in_pc;
  assign b0.out_ready = out_ready;
  assign b1.in_valid = in_valid;
  assign b1.in_inst = in_inst;
  assign b1.in_pc = in_pc;
  assign b1.out_ready = out_ready;
  assign rs1_d0 = rf[rs1_a0];
  assign rs2_d0 = rf[rs2_a0];
  assign rs1_d1 = rf[rs1_a1];
  assign rs2_d1 = rf[rs2_a1];

  id_stage #(.XLEN(32), .EN_M(1'b0), .NOP_INST(32'h00000013)) u0 (
    .clk(clk), .rst(rst), .bus(b0), .rs1_addr(rs1_a0), .rs2_addr(rs2_a0),
    .rs1_data(rs1_d0), .rs2_data(rs2_d0), .ld_valid(ld_valid), .ld_rd(ld_rd), .flush(flush));
  id_stage #(.XLEN(32), .EN_M(1'b1), .NOP_INST(32'h00000013)) u1 (
    .clk(clk), .rst(rst), .bus(b1), .rs1_addr(rs1_a1), .rs2_addr(rs2_a1),
    .rs1_data(rs1_d1), .rs2_data(rs2_d1), .ld_valid(ld_valid), .ld_rd(ld_rd), .flush(flush));

  assign got0 = {b0.out_valid, b0.out_pc, b0.out_inst, b0.out_alu_op, b0.out_op1, b0.out_op2,
                 b0.out_imm, b0.out_rd, b0.out_rd_we, b0.out_mem_rd, b0.out_mem_wr, b0.out_illegal};
  assign got1 = {b1.out_valid, b1.out_pc, b1.out_inst, b1.out_alu_op, b1.out_op1, b1.out_op2,
                 b1.out_imm, b1.out_rd, b1.out_rd_we, b1.out_mem_rd, b1.out_mem_wr, b1.out_illegal};

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bund_t empty_b();
    bund_t b = '0;
    b.inst = 32'h00000013;
    return b;
  endfunction

  // Decode by enumerating legal mnemonics rather than by field tables
  function automatic bund_t ref_dec(input logic [31:0] i, pc, r1, r2, input bit en_m);
    bund_t b;
    logic [31:0] iimm, imm;
    logic [6:0] f7;
    logic [2:0] f3;
    bit legal, wr, pcop1, rsop2;
    int op;
    f7 = i[31:25];
    f3 = i[14:12];
    iimm = 32'($signed(i) >>> 20);
    legal = 1; wr = 0; pcop1 = 0; rsop2 = 0; op = ALU_ADD; imm = 0;
    case (i[6:0])
      OP_LUI:   begin imm = {i[31:12], 12'h0}; wr = 1; op = ALU_LUI; end
      OP_AUIPC: begin imm = {i[31:12], 12'h0}; wr = 1; pcop1 = 1; end
      OP_JAL:   begin imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; wr = 1; pcop1 = 1; op = ALU_LINK; end
      OP_JALR:  begin imm = iimm; wr = 1; pcop1 = 1; op = ALU_LINK; legal = f3 == 0; end
      OP_BRANCH: begin
        imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        rsop2 = 1;
        case (f3)
          0: op = ALU_BEQ; 1: op = ALU_BNE; 4: op = ALU_BLT;
          5: op = ALU_BGE; 6: op = ALU_BLTU; 7: op = ALU_BGEU;
          default: legal = 0;
        endcase
      end
      OP_LOAD:  begin imm = iimm; wr = 1; legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; end
      OP_STORE: begin imm = {iimm[31:5], i[11:7]}; legal = f3 inside {3'd0, 3'd1, 3'd2}; end
      OP_IMM: begin
        imm = iimm; wr = 1;
        case (f3)
          0: op = ALU_ADD; 2: op = ALU_SLT; 3: op = ALU_SLTU; 4: op = ALU_XOR; 6: op = ALU_OR; 7: op = ALU_AND;
          1: if (f7 == 7'h00) op = ALU_SLL; else legal = 0;
          default: if (f7 == 7'h00) op = ALU_SRL; else if (f7 == 7'h20) op = ALU_SRA; else legal = 0;
        endcase
      end
      OP_REG: begin
        rsop2 = 1; wr = 1;
        if (f7 == 7'h01) begin legal = en_m; op = ALU_MUL + f3; end
        else case ({f7, f3})
          {7'h00, 3'd0}: op = ALU_ADD;  {7'h20, 3'd0}: op = ALU_SUB;
          {7'h00, 3'd1}: op = ALU_SLL;  {7'h00, 3'd2}: op = ALU_SLT;
          {7'h00, 3'd3}: op = ALU_SLTU; {7'h00, 3'd4}: op = ALU_XOR;
          {7'h00, 3'd5}: op = ALU_SRL;  {7'h20, 3'd5}: op = ALU_SRA;
          {7'h00, 3'd6}: op = ALU_OR;   {7'h00, 3'd7}: op = ALU_AND;
          default: legal = 0;
        endcase
      end
      OP_MISC: ;
      default: legal = 0;
    endcase
    b.v = 1; b.pc = pc; b.inst = i;
    b.op = legal ? 5'(op) : ALU_ADD;
    b.op1 = pcop1 ? pc : r1;
    b.op2 = rsop2 ? r2 : imm;
    b.imm = imm;
    b.rd = i[11:7];
    b.we = wr && legal && i[11:7] != 0;
    b.mrd = i[6:0] == OP_LOAD && legal;
    b.mwr = i[6:0] == OP_STORE && legal;
    b.ill = !legal;
    return b;
  endfunction

  function automatic bit ref_hazard(input logic [31:0] i);
    bit u1, u2;
    u1 = !(i[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL});
    u2 = i[6:0] inside {OP_REG, OP_STORE, OP_BRANCH};
    return ld_valid && ld_rd != 0 && ((u1 && i[19:15] == ld_rd) || (u2 && i[24:20] == ld_rd));
  endfunction

  // Inputs are already set just after a falling edge; advance one clock and compare.
  task automatic cycle();
    bund_t n0, n1;
    bit rdy;
    #1;
    rdy = !rst && !flush && !ref_hazard(in_inst) && (!e0.v || out_ready);
    chk("in_ready0", b0.in_ready, rdy);
    chk("in_ready1", b1.in_ready, rdy);
    chk("rs_addr", {rs1_a0, rs2_a0}, {in_inst[19:15], in_inst[24:20]});
    if (rst || flush) begin n0 = empty_b(); n1 = empty_b(); end
    else if (in_valid && rdy) begin
      n0 = ref_dec(in_inst, in_pc, rf[in_inst[19:15]], rf[in_inst[24:20]], 0);
      n1 = ref_dec(in_inst, in_pc, rf[in_inst[19:15]], rf[in_inst[24:20]], 1);
    end
    else if (out_ready) begin n0 = empty_b(); n1 = empty_b(); end
    else begin n0 = e0; n1 = e1; end
    @(posedge clk);
    e0 = n0;
    e1 = n1;
    @(negedge clk);
    chk("bundle0", got0, e0);
    chk("bundle1", got1, e1);
  endtask

  logic [6:0] opl [12] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
                           OP_IMM, OP_REG, OP_MISC, 7'b1110011, 7'b0000000};
  logic [6:0] f7l [4] = '{7'h00, 7'h20, 7'h01, 7'h7f};

  initial begin
    logic [31:0] w;
    int k;
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    rf[0] = 0;
    rf[1] = 7;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_valid", b0.out_valid, 1'b0);
    chk("rst_inst", b0.out_inst, 32'h00000013);
    chk("rst_op1", b0.out_op1, 32'h0);
    rst = 0;
    in_valid = 1; in_inst = 32'hFFF08293; in_pc = 32'h100;
    cycle();
    chk("t1_valid", b0.out_valid, 1'b1);
    chk("t1_imm", b0.out_imm, 32'hFFFFFFFF);
    chk("t1_op1", b0.out_op1, 32'd7);
    chk("t1_rd", b0.out_rd, 5'd5);
    chk("t1_we", b0.out_rd_we, 1'b1);
    ld_valid = 1; ld_rd = 3; in_inst = 32'h00218233; in_pc = 32'h104;
    cycle();
    chk("t2_stall", b0.in_ready, 1'b0);
    chk("t2_bubble", b0.out_valid, 1'b0);
    ld_valid = 0;
    cycle();
    chk("t2_add", b0.out_inst, 32'h00218233);
    out_ready = 0; in_inst = 32'h00500313; in_pc = 32'h108;
    snap = got0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("t3_hold", got0, snap);
      chk("t3_ready", b0.in_ready, 1'b0);
    end
    out_ready = 1;
    cycle();
    chk("t3_next", b0.out_inst, 32'h00500313);
    flush = 1; in_inst = 32'h00100093; in_pc = 32'h10c;
    #1 chk("t4_ready", b0.in_ready, 1'b0);
    cycle();
    chk("t4_valid", b0.out_valid, 1'b0);
    flush = 0; in_inst = 32'h023100B3; in_pc = 32'h110;
    cycle();
    chk("t5_ill0", b0.out_illegal, 1'b1);
    chk("t5_we0", b0.out_rd_we, 1'b0);
    chk("t5_op1", b1.out_alu_op, ALU_MUL);
    chk("t5_ill1", b1.out_illegal, 1'b0);
    ld_valid = 1; ld_rd = 3; in_inst = 32'h00218233; out_ready = 0;
    cycle();
    rst = 1;
    cycle();
    chk("t6_valid", b0.out_valid, 1'b0);
    chk("t6_inst", b0.out_inst, 32'h00000013);
    rst = 0; ld_valid = 0; out_ready = 1;
    for (int n = 0; n < 3000; n++) begin
      w = $urandom;
      k = $urandom_range(0, 11);
      if (k < 11) w[6:0] = opl[k];
      if (w[6:0] == OP_REG || w[6:0] == OP_IMM) w[31:25] = f7l[$urandom_range(0, 3)];
      in_inst = w;
      in_pc = $urandom & 32'hFFFFFFFC;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      ld_valid = $urandom_range(0, 2) == 0;
      k = $urandom_range(0, 3);
      ld_rd = k == 0 ? w[19:15] : k == 1 ? w[24:20] : 5'($urandom);
      flush = $urandom_range(0, 15) == 0;
      rst = $urandom_range(0, 49) == 0;
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
